// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, control-word bit
// positions and the sequencer state encoding.
package cpu_pkg;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_LOAD   = 8'h01;
  localparam logic [7:0] OP_STORE  = 8'h02;
  localparam logic [7:0] OP_ADD    = 8'h03;
  localparam logic [7:0] OP_SUB    = 8'h04;
  localparam logic [7:0] OP_JMP    = 8'h05;
  localparam logic [7:0] OP_JMPGEZ = 8'h06;
  localparam logic [7:0] OP_HALT   = 8'h07;

  localparam int C_MAR_PC  = 0;
  localparam int C_MBR_MEM = 1;
  localparam int C_IR_MBR  = 2;
  localparam int C_MAR_IR  = 3;
  localparam int C_MEM_MBR = 4;
  localparam int C_MBR_ACC = 5;
  localparam int C_PC_INC  = 6;
  localparam int C_ACC_MBR = 9;
  localparam int C_ACC_ADD = 10;
  localparam int C_ACC_SUB = 11;
  localparam int C_PC_JMP  = 14;

  localparam int CTRL_W = 16;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_F0   = 4'd1,
    ST_F1   = 4'd2,
    ST_F2   = 4'd3,
    ST_DEC  = 4'd4,
    ST_MRD  = 4'd5,
    ST_EX   = 4'd6,
    ST_MWR  = 4'd7,
    ST_HALT = 4'd8
  } state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter for a bus master: counts stalled request cycles and
// flags a timeout when the limit is reached with the access still stalled.
module mem_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_timeout
);

  localparam int CNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] L_MAX = CNT_W'(WAIT_MAX);

  logic [CNT_W-1:0] r_cnt;

  // Saturates at the limit so a held request never wraps back to zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != L_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_timeout = i_en && (r_cnt == L_MAX);

endmodule

// File: rtl/control_unit.sv
// Hardwired micro-sequencer for the accumulator CPU: fetch/decode/execute
// control word plus memory request handshake with wait-state timeout.
module control_unit
  import cpu_pkg::*;
#(
  parameter int OPC_W    = 8,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OPC_W-1:0]  opcode,
  input  logic              acc_neg,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [CTRL_W-1:0] ctrl,
  output logic              halted,
  output logic              bus_err,
  output logic              illegal_op
);

  state_t r_state;
  state_t w_next;
  logic   r_bus_err;
  logic   w_req_state;
  logic   w_timeout;

  // Request qualification depends on state alone, keeping the timer path acyclic.
  assign w_req_state = (r_state == ST_F1) || (r_state == ST_MRD) || (r_state == ST_MWR);

  mem_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_clr     (!w_req_state || mem_ready),
    .i_en      (w_req_state && !mem_ready),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_bus_err <= r_bus_err || w_timeout;
    end
  end

  always_comb begin
    w_next     = r_state;
    ctrl       = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    illegal_op = 1'b0;
    case (r_state)
      ST_IDLE: w_next = ST_F0;
      ST_F0: begin
        ctrl[C_MAR_PC] = 1'b1;
        w_next         = ST_F1;
      end
      ST_F1: begin
        mem_req = 1'b1;
        if (w_timeout) begin
          w_next = ST_HALT;
        end else if (mem_ready) begin
          ctrl[C_MBR_MEM] = 1'b1;
          ctrl[C_PC_INC]  = 1'b1;
          w_next          = ST_F2;
        end
      end
      ST_F2: begin
        ctrl[C_IR_MBR] = 1'b1;
        w_next         = ST_DEC;
      end
      ST_DEC: begin
        w_next = ST_F0;
        case (opcode)
          OPC_W'(OP_LOAD), OPC_W'(OP_ADD), OPC_W'(OP_SUB): begin
            ctrl[C_MAR_IR] = 1'b1;
            w_next         = ST_MRD;
          end
          OPC_W'(OP_STORE): begin
            ctrl[C_MAR_IR]  = 1'b1;
            ctrl[C_MBR_ACC] = 1'b1;
            w_next          = ST_MWR;
          end
          OPC_W'(OP_JMP):    ctrl[C_PC_JMP] = 1'b1;
          OPC_W'(OP_JMPGEZ): ctrl[C_PC_JMP] = !acc_neg;
          OPC_W'(OP_HALT):   w_next = ST_HALT;
          OPC_W'(OP_NOP):    w_next = ST_F0;
          default:           illegal_op = 1'b1;
        endcase
      end
      ST_MRD: begin
        mem_req = 1'b1;
        if (w_timeout) begin
          w_next = ST_HALT;
        end else if (mem_ready) begin
          ctrl[C_MBR_MEM] = 1'b1;
          w_next          = ST_EX;
        end
      end
      ST_EX: begin
        w_next = ST_F0;
        case (opcode)
          OPC_W'(OP_LOAD): ctrl[C_ACC_MBR] = 1'b1;
          OPC_W'(OP_ADD):  ctrl[C_ACC_ADD] = 1'b1;
          OPC_W'(OP_SUB):  ctrl[C_ACC_SUB] = 1'b1;
          default:         ctrl = '0;
        endcase
      end
      ST_MWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (w_timeout) begin
          w_next = ST_HALT;
        end else if (mem_ready) begin
          ctrl[C_MEM_MBR] = 1'b1;
          w_next          = ST_F0;
        end
      end
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_IDLE;
    endcase
  end

  assign halted  = (r_state == ST_HALT);
  assign bus_err = r_bus_err;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: builds the expected per-cycle trace of each
// instruction from the instruction-level rules, then replays it on the DUT.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  opcode = 8'h00;
  logic        acc_neg = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, halted, bus_err, illegal_op;
  logic [15:0] ctrl;

  control_unit #(.OPC_W(8), .WAIT_MAX(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .acc_neg    (acc_neg),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .ctrl       (ctrl),
    .halted     (halted),
    .bus_err    (bus_err),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic [7:0]  op;
    logic        an;
    logic [15:0] ctrl;
    logic        req;
    logic        we;
    logic        ill;
    logic        hlt;
    logic        berr;
  } cyc_t;

  cyc_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic m_berr = 1'b0;

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input logic rdy, input logic [7:0] op, input logic an, input logic [15:0] c,
                      input logic req, input logic we, input logic ill, input logic hlt);
    cyc_t r;
    r.rdy = rdy; r.op = op; r.an = an; r.ctrl = c; r.req = req; r.we = we;
    r.ill = ill; r.hlt = hlt; r.berr = m_berr;
    q.push_back(r);
  endtask

  task automatic add_halted(input logic [7:0] op, input logic an, input int n);
    for (int i = 0; i < n; i++) push(rnd(), op, an, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Expected trace of one instruction starting at F0; wf/wm are stalled cycles
  // before mem_ready in the fetch and operand accesses. 16+ stalls time out.
  task automatic add_instr(input logic [7:0] op, input logic an, input int wf, input int wm);
    push(rnd(), op, an, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < wf && i < 16; i++) push(1'b0, op, an, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    if (wf >= 16) begin
      m_berr = 1'b1;
      add_halted(op, an, 4);
    end else begin
      push(1'b1, op, an, 16'h0042, 1'b1, 1'b0, 1'b0, 1'b0);
      push(rnd(), op, an, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0);
      case (op)
        8'h01, 8'h03, 8'h04: begin
          push(rnd(), op, an, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b0);
          for (int i = 0; i < wm; i++) push(1'b0, op, an, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
          push(1'b1, op, an, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0);
          push(rnd(), op, an, (op == 8'h01) ? 16'h0200 : (op == 8'h03) ? 16'h0400 : 16'h0800,
               1'b0, 1'b0, 1'b0, 1'b0);
        end
        8'h02: begin
          push(rnd(), op, an, 16'h0028, 1'b0, 1'b0, 1'b0, 1'b0);
          for (int i = 0; i < wm; i++) push(1'b0, op, an, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
          push(1'b1, op, an, 16'h0010, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        8'h05: push(rnd(), op, an, 16'h4000, 1'b0, 1'b0, 1'b0, 1'b0);
        8'h06: push(rnd(), op, an, an ? 16'h0000 : 16'h4000, 1'b0, 1'b0, 1'b0, 1'b0);
        8'h07: begin
          push(rnd(), op, an, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
          add_halted(op, an, 3);
        end
        8'h00: push(rnd(), op, an, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        default: push(rnd(), op, an, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
      endcase
    end
  endtask

  // Entered and left one time unit after a rising edge.
  task automatic run_queue();
    cyc_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      mem_ready = r.rdy;
      opcode    = r.op;
      acc_neg   = r.an;
      @(negedge clk);
      chk("ctrl", ctrl, r.ctrl);
      chk("mem_req", 16'(mem_req), 16'(r.req));
      if (r.req) chk("mem_we", 16'(mem_we), 16'(r.we));
      chk("illegal_op", 16'(illegal_op), 16'(r.ill));
      chk("halted", 16'(halted), 16'(r.hlt));
      chk("bus_err", 16'(bus_err), 16'(r.berr));
      chk("c6_with_c14", 16'(ctrl[6] & ctrl[14]), 16'h0000);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_ctrl", ctrl, 16'h0000);
    chk("rst_mem_req", 16'(mem_req), 16'h0000);
    chk("rst_halted", 16'(halted), 16'h0000);
    chk("rst_bus_err", 16'(bus_err), 16'h0000);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    m_berr = 1'b0;
    push(rnd(), 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] op;
    int         r;
    #12;
    chk("por_ctrl", ctrl, 16'h0000);
    chk("por_mem_req", 16'(mem_req), 16'h0000);
    chk("por_halted", 16'(halted), 16'h0000);
    #4;
    rst_n = 1'b1;
    push(1'b1, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) add_instr(8'h00, 1'b0, 0, 0);
    run_queue();

    for (int i = 0; i < 60; i++) begin
      r  = $urandom_range(0, 7);
      op = (r < 7) ? 8'(r) : 8'($urandom_range(8, 255));
      add_instr(op, rnd(), $urandom_range(0, 4), $urandom_range(0, 4));
    end
    run_queue();

    add_instr(8'h06, 1'b1, 0, 0);
    add_instr(8'h06, 1'b0, 0, 0);
    add_instr(8'h01, 1'b0, 0, 2);
    add_instr(8'h02, 1'b1, 0, 0);
    add_instr(8'hFF, 1'b0, 0, 0);
    add_instr(8'h00, 1'b0, 15, 0);
    add_instr(8'h03, 1'b0, 0, 15);
    add_instr(8'h00, 1'b0, 16, 0);
    run_queue();

    do_reset();
    push(1'b1, 8'h02, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b1, 8'h02, 1'b0, 16'h0042, 1'b1, 1'b0, 1'b0, 1'b0);
    push(1'b0, 8'h02, 1'b0, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b0, 8'h02, 1'b0, 16'h0028, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b0, 8'h02, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    push(1'b0, 8'h02, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    run_queue();
    mem_ready = 1'b0;
    #1;
    chk("mwr_req_before_rst", 16'(mem_req), 16'h0001);
    do_reset();
    add_instr(8'h00, 1'b0, 1, 0);
    add_instr(8'h07, 1'b0, 0, 0);
    run_queue();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Hardwired micro-sequencer that drives the datapath control lines C0..C15 of the accumulator CPU. It consumes the opcode field of IR and the accumulator sign flag. It produces the one-hot-per-function control word, including C6 (PC increment) and C14 (PC load from IR[7:0]) consumed by the program counter. It also owns the memory request/ready handshake, with a wait-state timeout.

Parameters:
OPC_W, 8, opcode width (IR[15:8])
WAIT_MAX, 15, max cycles a memory access may wait for mem_ready before bus error

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  OPC_W  IR[15:8], valid from the cycle after C2
acc_neg  input  1  ACC[15], sampled in DECODE
mem_ready  input  1  memory completes access this cycle
mem_req  output  1  memory access request, held until mem_ready
mem_we  output  1  1=write, 0=read; valid while mem_req=1
ctrl  output  16  control word; bit n = Cn
halted  output  1  CPU stopped (HALT executed or bus error)
bus_err  output  1  sticky; memory timeout occurred
illegal_op  output  1  one-cycle pulse on undefined opcode

Behaviour:
- Control bit map (all others reserved, driven 0):
  - C0 MAR<-PC; C1 MBR<-mem; C2 IR<-MBR; C3 MAR<-IR[7:0]; C4 mem<-MBR; C5 MBR<-ACC; C6 PC<-PC+1.
  - C9 ACC<-MBR; C10 ACC<-ACC+MBR; C11 ACC<-ACC-MBR; C14 PC<-IR[7:0].
- Opcodes: 0x01 LOAD, 0x02 STORE, 0x03 ADD, 0x04 SUB, 0x05 JMP, 0x06 JMPGEZ, 0x07 HALT, 0x00 NOP. All others are illegal.
- States: IDLE, F0, F1, F2, DEC, MRD, EX, MWR, HALT. Reset forces IDLE.
- IDLE: all outputs 0. Unconditionally goes to F0 next cycle.
- F0: C0 -> F1.
- F1: mem_req=1, mem_we=0.
  - Stay while mem_ready=0.
  - In the mem_ready=1 cycle, assert C1 and C6 -> F2.
- F2: C2 -> DEC.
- DEC, by opcode:
  - LOAD/ADD/SUB: C3 -> MRD.
  - STORE: C3 and C5 -> MWR.
  - JMP: C14 -> F0.
  - JMPGEZ: C14 only if acc_neg=0 -> F0.
  - HALT -> HALT.
  - NOP -> F0.
  - Illegal: illegal_op=1 for this cycle -> F0, executed as NOP.
- MRD: mem_req=1, mem_we=0; wait for mem_ready; C1 in the ready cycle -> EX.
- EX: C9 (LOAD), C10 (ADD) or C11 (SUB), selected by the opcode held in IR -> F0.
- MWR: mem_req=1, mem_we=1; wait for mem_ready; C4 in the ready cycle -> F0.
- HALT: ctrl=0, mem_req=0, halted=1. Exited only by reset.
- Output timing:
  - ctrl, mem_req and mem_we are combinational from state, opcode, acc_neg and mem_ready.
  - Bits qualified by mem_ready (C1, C4, C6) are asserted only in the ready cycle.
- Wait counter:
  - Width ceil(log2(WAIT_MAX+1)); cleared on entry to F1, MRD and MWR.
  - Increments each cycle mem_req=1 and mem_ready=0.
  - Timeout: counter reaches WAIT_MAX with mem_ready still 0. Next state is HALT, bus_err=1 (sticky), and no C1/C4/C6 is issued.
- Invariants:
  - C6 and C14 are never asserted together.
  - mem_req never deasserts before mem_ready.
- Zero-wait cycle counts: NOP/JMP 4, STORE 5, LOAD/ADD/SUB 6.
- Reset mid-operation: all outputs drop to 0 immediately (asynchronous). On rst_n release, IDLE then F0; bus_err and halted are cleared.

Decomposition:
- Shared package (cpu_pkg):
  - opcode constants (OP_NOP..OP_HALT);
  - control-bit index constants (C_MAR_PC=0 .. C_PC_JMP=14);
  - state encoding constants.
- One natural sub-module: mem_wait_timer (counter, clear, timeout flag), reusable by future bus masters.

Test Plan:
- Reset release, mem_ready tied 1, opcode=0x00:
  - ctrl sequence IDLE:0x0000, F0:0x0001, F1:0x0042, F2:0x0004, DEC:0x0000.
  - Then F0 repeats every 4 cycles.
- LOAD with 2 wait states in MRD:
  - mem_req high 3 cycles, mem_we=0; C1 only in the 3rd cycle.
  - Next cycle ctrl=0x0200; instruction takes 8 cycles.
- JMPGEZ twice:
  - acc_neg=1: DEC ctrl=0x0000.
  - acc_neg=0: DEC ctrl=0x4000.
  - C6 is never asserted in a cycle with C14.
- STORE, zero wait:
  - DEC ctrl=0x0028; MWR mem_req=1, mem_we=1, ctrl=0x0010; back to F0.
- mem_ready held 0 in F1, WAIT_MAX=15:
  - After 16 request cycles: state HALT, bus_err=1, halted=1, ctrl=0.
  - No C6 is ever issued.
- Opcode 0xFF:
  - illegal_op pulses 1 cycle in DEC, then continues to F0.
- rst_n low during MWR:
  - mem_req=0 immediately; bus_err=0 after release.
